uart_transceiver: RTL and testbench
===================================

UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 Parameter CLOCK_SPEED, default 2_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate; CLKS_PER_BIT = CLOCK_SPEED/BAUD_RATE (integer division, 208 at defaults).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 tx_parallel_in_data  input  DATA_WIDTH(8)  byte to transmit.
REQ-006 tx_start_strobe  input  1  request to start a TX frame.
REQ-007 busy_flag  output  1  high while a TX frame is in progress.
REQ-008 data_out  output  1  TX serial line, idle high.
REQ-009 rx_serial_in_data  input  1  RX serial line, asynchronous, idle high.
REQ-010 rx_strobe_data_ready  output  1  one-cycle pulse when a valid byte is received.
REQ-011 rx_parallel_data_out  output  DATA_WIDTH(8)  last valid received byte, held until next valid byte.
REQ-012 rx_status  output  2  bit0 framing error of last frame; bit1 receive in progress.

Function
REQ-013 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity; each bit CLKS_PER_BIT cycles.
REQ-014 TX FSM states S_UART_TX_IDLE, S_UART_TX_START, S_UART_TX_DATA, S_UART_TX_STOP; transitions on bit-counter terminal count.
REQ-015 In IDLE, tx_start_strobe high on a rising edge latches tx_parallel_in_data and enters START; strobe is level-sampled only in IDLE, ignored otherwise.
REQ-016 A strobe held high through frame end starts the next frame immediately after the one IDLE cycle; no strobe is queued while busy.
REQ-017 busy_flag high from the cycle after acceptance until stop bit completes; data_out registered, high in IDLE.
REQ-018 RX input double-flop synchronized before use.
REQ-019 RX FSM states S_UART_RX_IDLE, S_UART_RX_START, S_UART_RX_DATA, S_UART_RX_STOP.
REQ-020 IDLE->START on synchronized line low; at CLKS_PER_BIT/2 re-sample: low -> DATA, high -> IDLE (glitch rejected, no status change).
REQ-021 DATA samples each bit every CLKS_PER_BIT cycles at bit center, shifting LSB first; after 8 bits -> STOP.
REQ-022 At stop-bit center: high -> update rx_parallel_data_out, pulse rx_strobe_data_ready exactly one cycle, clear rx_status[0]; low -> set rx_status[0], no pulse, data output unchanged; then IDLE.
REQ-023 After a framing error, RX stays in IDLE until line seen high before accepting a new start edge.
REQ-024 rx_status[1] high in START, DATA, STOP; low in IDLE.
REQ-025 TX and RX independent; loopback (data_out to rx_serial_in_data) must work back-to-back.

Reset
REQ-026 reset low at a rising edge: both FSMs to IDLE, counters and shift registers 0, data_out=1, busy_flag=0, rx_strobe_data_ready=0, rx_parallel_data_out=0, rx_status=2'b00.
REQ-027 Reset mid-frame aborts the frame immediately; no partial byte or ready pulse emitted.

Structure
REQ-028 DATA_WIDTH (8) from arch_defs_pkg; TX and RX state enums defined in arch_defs_pkg.
REQ-029 uart_transceiver instantiates two sub-modules, uart_transmitter and uart_receiver, each with its own bit-period counter; port names as above.

Verification
REQ-030 Loopback, defaults: strobe 0xB2 one cycle after reset -> busy_flag rises next cycle, rx_strobe_data_ready pulses once with rx_parallel_data_out=0xB2 within 1990 cycles, rx_status=00 after.
REQ-031 Strobe 0xA5 held high 300 cycles starting at cycle 2002 of the prior frame -> ignored while busy, frame 0xA5 starts after IDLE, exactly one 0xA5 received, no duplicate.
REQ-032 TX bit timing: 0x55 -> each line level lasts 208 cycles, start=0, bits alternate 1/0 LSB first, stop=1, busy low after 2080 cycles.
REQ-033 RX line low 50 cycles then high -> no pulse, rx_status back to 00, next valid frame 0x3C received correctly.
REQ-034 Frame 0x81 with stop bit forced 0 -> rx_status[0]=1, no pulse, data output keeps previous value; following good frame clears bit0.
REQ-035 Reset asserted mid-TX at bit 4 -> data_out=1, busy_flag=0 next cycle; no RX pulse.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// Shared widths, FSM state encodings and status payload for the UART transceiver.
package arch_defs_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_UART_TX_IDLE  = 2'd0,
        S_UART_TX_START = 2'd1,
        S_UART_TX_DATA  = 2'd2,
        S_UART_TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        S_UART_RX_IDLE  = 2'd0,
        S_UART_RX_START = 2'd1,
        S_UART_RX_DATA  = 2'd2,
        S_UART_RX_STOP  = 2'd3
    } rx_state_t;

    // Receiver status word: bit1 = frame in progress, bit0 = framing error of last frame.
    typedef struct packed {
        logic rx_active;
        logic frame_err;
    } rx_status_t;

endpackage

// File: rtl/uart_receiver.sv
// UART receiver: synchronizes the line, validates the start bit at half period, samples bits at center.
module uart_receiver
    import arch_defs_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 208
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_serial_in_data,
    output logic                  rx_strobe_data_ready,
    output logic [DATA_WIDTH-1:0] rx_parallel_data_out,
    output logic [1:0]            rx_status
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
    localparam int unsigned HALF  = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    rx_state_t             r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [CNT_W-1:0]      r_clk_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ready;
    logic                  r_wait_high;
    rx_status_t            r_status;
    logic                  w_rx_line;

    assign w_rx_line = r_sync2;

    // Two-flop synchronizer plus receive sequencer; r_wait_high blocks restarts on a line stuck low after a framing error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_UART_RX_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_ready     <= 1'b0;
            r_wait_high <= 1'b0;
            r_status    <= '0;
        end else begin
            r_sync1 <= rx_serial_in_data;
            r_sync2 <= r_sync1;
            r_ready <= 1'b0;
            case (r_state)
                S_UART_RX_IDLE: begin
                    r_clk_cnt          <= '0;
                    r_bit_idx          <= '0;
                    r_status.rx_active <= 1'b0;
                    if (r_wait_high) begin
                        if (w_rx_line) begin
                            r_wait_high <= 1'b0;
                        end
                    end else if (!w_rx_line) begin
                        r_status.rx_active <= 1'b1;
                        r_state            <= S_UART_RX_START;
                    end
                end
                S_UART_RX_START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= '0;
                        if (!w_rx_line) begin
                            r_state <= S_UART_RX_DATA;
                        end else begin
                            r_status.rx_active <= 1'b0;
                            r_state            <= S_UART_RX_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_UART_RX_DATA: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx_line, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_idx == IDX_LAST) begin
                            r_state <= S_UART_RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_UART_RX_STOP: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt          <= '0;
                        r_status.rx_active <= 1'b0;
                        r_state            <= S_UART_RX_IDLE;
                        if (w_rx_line) begin
                            r_data             <= r_shift;
                            r_ready            <= 1'b1;
                            r_status.frame_err <= 1'b0;
                        end else begin
                            r_status.frame_err <= 1'b1;
                            r_wait_high        <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_UART_RX_IDLE;
                end
            endcase
        end
    end

    assign rx_strobe_data_ready = r_ready;
    assign rx_parallel_data_out = r_data;
    assign rx_status            = r_status;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 1 start, DATA_WIDTH data bits LSB first, 1 stop, no parity.
module uart_transmitter
    import arch_defs_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 208
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_parallel_in_data,
    input  logic                  tx_start_strobe,
    output logic                  busy_flag,
    output logic                  data_out
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    logic [CNT_W-1:0]      r_clk_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_busy;
    logic                  r_tx;

    // Frame sequencer; the line level for the next bit is loaded on the edge that ends the current one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_UART_TX_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_UART_TX_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                    if (tx_start_strobe) begin
                        r_shift <= tx_parallel_in_data;
                        r_busy  <= 1'b1;
                        r_tx    <= 1'b0;
                        r_state <= S_UART_TX_START;
                    end
                end
                S_UART_TX_START: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_UART_TX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_UART_TX_DATA: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == IDX_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= S_UART_TX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_shift   <= {1'b0, r_shift[DATA_WIDTH-1:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_UART_TX_STOP: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_UART_TX_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_UART_TX_IDLE;
                end
            endcase
        end
    end

    assign busy_flag = r_busy;
    assign data_out  = r_tx;

endmodule

// File: rtl/uart_transceiver.sv
// UART transceiver top: independent transmitter and receiver sharing one clock and reset.
module uart_transceiver
    import arch_defs_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED = 2_000_000,
    parameter int unsigned BAUD_RATE   = 9600
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_parallel_in_data,
    input  logic                  tx_start_strobe,
    output logic                  busy_flag,
    output logic                  data_out,
    input  logic                  rx_serial_in_data,
    output logic                  rx_strobe_data_ready,
    output logic [DATA_WIDTH-1:0] rx_parallel_data_out,
    output logic [1:0]            rx_status
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;

    // Transmit path
    uart_transmitter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk                 (clk),
        .reset               (reset),
        .tx_parallel_in_data (tx_parallel_in_data),
        .tx_start_strobe     (tx_start_strobe),
        .busy_flag           (busy_flag),
        .data_out            (data_out)
    );

    // Receive path
    uart_receiver #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk                  (clk),
        .reset                (reset),
        .rx_serial_in_data    (rx_serial_in_data),
        .rx_strobe_data_ready (rx_strobe_data_ready),
        .rx_parallel_data_out (rx_parallel_data_out),
        .rx_status            (rx_status)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed self-checking bench for uart_transceiver at default parameters (208 clocks per bit).
module tb_uart_transceiver;

    localparam int unsigned CPB = 208;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic       busy;
    logic       txd;
    logic       rx_line;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic [1:0] rx_status;
    logic       loop_en;
    logic       rx_drv;

    int         total = 0;
    int         bad = 0;
    int         pulse_cnt = 0;
    logic [7:0] rx_log[$];

    always #5 clk = ~clk;

    assign rx_line = loop_en ? txd : rx_drv;

    uart_transceiver dut (
        .clk                  (clk),
        .reset                (reset),
        .tx_parallel_in_data  (tx_data),
        .tx_start_strobe      (tx_strobe),
        .busy_flag            (busy),
        .data_out             (txd),
        .rx_serial_in_data    (rx_line),
        .rx_strobe_data_ready (rx_rdy),
        .rx_parallel_data_out (rx_data),
        .rx_status            (rx_status)
    );

    // Receive monitor: count every ready cycle and log the byte presented with it.
    always @(negedge clk) begin
        if (rx_rdy === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            rx_log.push_back(rx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulses(input int target, input int budget, input string tag);
        int n = 0;
        while (pulse_cnt < target && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check(tag, 32'(pulse_cnt), 32'(target));
    endtask

    // One-cycle strobe; returns on the negedge right after the accepting rising edge.
    task automatic send_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data   = d;
        tx_strobe = 1'b1;
        @(negedge clk);
        tx_strobe = 1'b0;
    endtask

    // Drive a full frame on the RX line from the bench, each level for CPB cycles.
    task automatic drive_frame(input logic [7:0] d, input logic stop_lvl);
        logic lvl;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      lvl = 1'b0;
            else if (b == 9) lvl = stop_lvl;
            else             lvl = d[b-1];
            @(negedge clk);
            rx_drv = lvl;
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    initial begin
        logic       ok;
        logic [9:0] frame;

        reset     = 1'b0;
        tx_data   = 8'h00;
        tx_strobe = 1'b0;
        loop_en   = 1'b1;
        rx_drv    = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(txd), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(rx_rdy), 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_status", 32'(rx_status), 32'h0);

        // Loopback 0xB2 one cycle after reset release
        reset = 1'b1;
        send_tx(8'hB2);
        check("b2_busy_rise", 32'(busy), 32'h1);
        check("b2_start_bit", 32'(txd), 32'h0);
        wait_pulses(1, 1990, "b2_pulse");
        check("b2_data", 32'(rx_data), 32'hB2);
        repeat (110) @(negedge clk);
        check("b2_busy_done", 32'(busy), 32'h0);
        check("b2_status", 32'(rx_status), 32'h0);
        check("b2_single", 32'(pulse_cnt), 32'd1);

        // Bit timing for 0x55
        frame = {1'b1, 8'h55, 1'b0};
        send_tx(8'h55);
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < int'(CPB); c++) begin
                if (txd !== frame[b]) ok = 1'b0;
                @(negedge clk);
            end
            check($sformatf("tx55_bit%0d", b), 32'(ok), 32'h1);
        end
        check("tx55_busy_2080", 32'(busy), 32'h0);
        check("tx55_idle_line", 32'(txd), 32'h1);
        wait_pulses(2, 50, "tx55_pulse");
        check("tx55_rx_data", 32'(rx_data), 32'h55);

        // Strobe held high across a busy frame: one extra frame only
        send_tx(8'h96);
        repeat (2001) @(negedge clk);
        tx_data   = 8'hA5;
        tx_strobe = 1'b1;
        repeat (79) @(negedge clk);
        check("hold_idle_gap", 32'(busy), 32'h0);
        @(negedge clk);
        check("hold_accept", 32'(busy), 32'h1);
        check("hold_start_bit", 32'(txd), 32'h0);
        repeat (220) @(negedge clk);
        tx_strobe = 1'b0;
        wait_pulses(4, 2000, "hold_pulse");
        check("hold_a5_data", 32'(rx_data), 32'hA5);
        repeat (2500) @(negedge clk);
        check("hold_no_dup", 32'(pulse_cnt), 32'd4);
        check("hold_busy_end", 32'(busy), 32'h0);
        if (rx_log.size() >= 4) begin
            check("hold_prior_byte", 32'(rx_log[2]), 32'h96);
        end

        // Start glitch rejection, then a valid 0x3C
        @(negedge clk);
        loop_en = 1'b0;
        repeat (10) @(negedge clk);
        rx_drv = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_active", 32'(rx_status), 32'h2);
        repeat (40) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_pulse", 32'(pulse_cnt), 32'd4);
        check("glitch_status", 32'(rx_status), 32'h0);
        drive_frame(8'h3C, 1'b1);
        wait_pulses(5, 50, "rx3c_pulse");
        check("rx3c_data", 32'(rx_data), 32'h3C);
        check("rx3c_status", 32'(rx_status), 32'h0);

        // Framing error on 0x81, then recovery with 0x5A
        repeat (20) @(negedge clk);
        drive_frame(8'h81, 1'b0);
        repeat (5) @(negedge clk);
        check("ferr_status", 32'(rx_status), 32'h1);
        check("ferr_no_pulse", 32'(pulse_cnt), 32'd5);
        check("ferr_hold_data", 32'(rx_data), 32'h3C);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        drive_frame(8'h5A, 1'b1);
        wait_pulses(6, 50, "rx5a_pulse");
        check("rx5a_data", 32'(rx_data), 32'h5A);
        check("rx5a_status", 32'(rx_status), 32'h0);

        // Reset during data bit 4 of a loopback frame
        loop_en = 1'b1;
        repeat (5) @(negedge clk);
        send_tx(8'hF0);
        repeat (1140) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_data_out", 32'(txd), 32'h1);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_status", 32'(rx_status), 32'h0);
        check("midrst_rx_data", 32'(rx_data), 32'h0);
        reset = 1'b1;
        repeat (2300) @(negedge clk);
        check("midrst_no_pulse", 32'(pulse_cnt), 32'd6);
        check("midrst_idle_line", 32'(txd), 32'h1);
        check("midrst_busy_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
